// File: rtl/frs_message_arbiter.sv
// Round-robin arbiter that feeds FRS messages from NUM_REQ sources into the FRS
// message queue register and tracks queue occupancy so the depth field never wraps.
module frs_message_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int FUNCTION_ID_WIDTH = 16,
  parameter int REASON_WIDTH      = 4,
  parameter int MAX_QUEUE_SIZE    = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 arb_enable,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*FUNCTION_ID_WIDTH-1:0] req_function_id,
  input  logic [NUM_REQ*REASON_WIDTH-1:0]      req_reason,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 message_removed,
  output logic                                 message_received,
  output logic [FUNCTION_ID_WIDTH-1:0]         new_message_function_id,
  output logic [REASON_WIDTH-1:0]              new_message_reason,
  output logic [$clog2(MAX_QUEUE_SIZE):0]      occupancy,
  output logic                                 full,
  output logic                                 underflow_err
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(MAX_QUEUE_SIZE) + 1;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MAX_QUEUE_SIZE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                                   state_q, state_d;
  logic [PTR_W-1:0]                         rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]                         occ_q, occ_d;
  logic                                     uf_q, uf_d;
  logic                                     msg_vld_q;
  logic [FUNCTION_ID_WIDTH-1:0]             fid_q, fid_d;
  logic [REASON_WIDTH-1:0]                  rsn_q, rsn_d;

  logic [NUM_REQ-1:0][FUNCTION_ID_WIDTH-1:0] fid_arr;
  logic [NUM_REQ-1:0][REASON_WIDTH-1:0]      rsn_arr;
  logic                                      grant_en;
  logic                                      gnt_any;
  logic [PTR_W-1:0]                          gnt_idx;
  logic [NUM_REQ-1:0]                        gnt;
  logic [PTR_W:0]                            sidx;
  logic [PTR_W-1:0]                          cand;

  assign fid_arr  = req_function_id;
  assign rsn_arr  = req_reason;
  assign full     = (occ_q == OCC_MAX);
  assign grant_en = (state_q == RUN) && !full;

  // First valid source at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sidx    = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sidx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sidx >= (PTR_W+1)'(NUM_REQ)) sidx = sidx - (PTR_W+1)'(NUM_REQ);
      cand = sidx[PTR_W-1:0];
      if (!gnt_any && grant_en && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    fid_d    = fid_q;
    rsn_d    = rsn_q;
    occ_d    = occ_q;
    uf_d     = uf_q;
    case (state_q)
      IDLE:    if (arb_enable)  state_d = RUN;
      RUN:     if (!arb_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (gnt_any) begin
      fid_d    = fid_arr[gnt_idx];
      rsn_d    = rsn_arr[gnt_idx];
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    // Simultaneous issue and removal cancel out; a removal at zero is an error.
    if (gnt_any && !message_removed)                       occ_d = occ_q + 1'b1;
    else if (!gnt_any && message_removed && occ_q != '0)   occ_d = occ_q - 1'b1;
    if (message_removed && occ_q == '0) uf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      occ_q     <= '0;
      uf_q      <= 1'b0;
      msg_vld_q <= 1'b0;
      fid_q     <= '0;
      rsn_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      occ_q     <= occ_d;
      uf_q      <= uf_d;
      msg_vld_q <= gnt_any;
      fid_q     <= fid_d;
      rsn_q     <= rsn_d;
    end
  end

  assign message_received        = msg_vld_q;
  assign new_message_function_id = fid_q;
  assign new_message_reason      = rsn_q;
  assign occupancy               = occ_q;
  assign underflow_err           = uf_q;

endmodule
